// File: rtl/memory_pkg.sv
// Shared constants for the memory-game autoplayer.
// Holds FSM state codes, button one-hot indices and the default coordinate width.
package memory_pkg;

  localparam int CW_DEF = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_CMP   = 3'd2;
  localparam logic [2:0] ST_PULSE = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  localparam int NBTN  = 5;
  localparam int BTN_R = 0;
  localparam int BTN_L = 1;
  localparam int BTN_D = 2;
  localparam int BTN_U = 3;
  localparam int BTN_S = 4;

endpackage

// File: rtl/memory_btn_pulser.sv
// Button pulser: drives a one-cycle one-hot pulse, then GAP_CYC low cycles.
// Ports: clk_i, rst_ni (sync, active-low), kill_i, start_i, req_i -> btn_o, done_o.
module memory_btn_pulser
  import memory_pkg::*;
#(
  parameter int GAP_CYC = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            kill_i,
  input  logic            start_i,
  input  logic [NBTN-1:0] req_i,
  output logic [NBTN-1:0] btn_o,
  output logic            done_o
);

  localparam int GW = $clog2(GAP_CYC + 1);

  logic [NBTN-1:0] btn_q;
  logic [GW-1:0]   cnt_q;
  logic            gap_q;

  // done marks the last low cycle after a pulse
  assign done_o = gap_q && (cnt_q == GW'(1));
  assign btn_o  = btn_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || kill_i) begin
      btn_q <= '0;
      cnt_q <= '0;
      gap_q <= 1'b0;
    end else begin
      btn_q <= start_i ? req_i : '0;
      if (|btn_q) begin
        gap_q <= 1'b1;
        cnt_q <= GW'(GAP_CYC);
      end else if (gap_q) begin
        cnt_q <= cnt_q - 1'b1;
        if (done_o) gap_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/memory_autoplayer.sv
// Autoplayer: steers the game cursor to each target cell and selects it.
// Ports: Clk, Reset, Enable, Qp, CurX/CurY, TgtX/TgtY, Tgt_valid/ready -> buttons, Busy, Err, Presses.
module memory_autoplayer
  import memory_pkg::*;
#(
  parameter int CW        = CW_DEF,
  parameter int GRID_W    = 4,
  parameter int GRID_H    = 4,
  parameter int GAP_CYC   = 1,
  parameter int MAX_STALL = 3
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Enable,
  input  logic          Qp,
  input  logic [CW-1:0] CurX,
  input  logic [CW-1:0] CurY,
  input  logic [CW-1:0] TgtX,
  input  logic [CW-1:0] TgtY,
  input  logic          Tgt_valid,
  output logic          Tgt_ready,
  output logic          Right,
  output logic          Left,
  output logic          Down,
  output logic          Up,
  output logic          Select,
  output logic          Busy,
  output logic          Err,
  output logic [7:0]    Presses
);

  localparam int SW = $clog2(MAX_STALL + 1);
  localparam logic [CW:0]   GW_L = (CW+1)'(GRID_W);
  localparam logic [CW:0]   GH_L = (CW+1)'(GRID_H);
  localparam logic [SW-1:0] MS_L = SW'(MAX_STALL);

  logic [2:0]      state_q, state_d;
  logic [CW-1:0]   tx_q, tx_d, ty_q, ty_d;
  logic [CW-1:0]   sx_q, sx_d, sy_q, sy_d;
  logic [SW-1:0]   stall_q, stall_d, stall_nx;
  logic            err_q, err_d, sel_q, sel_d;
  logic            rdy_q, busy_q;
  logic [7:0]      cnt_q, cnt_d;
  logic            go, start, done, moved, oor;
  logic [NBTN-1:0] req, btn;

  assign go    = Enable && Qp;
  assign oor   = ({1'b0, TgtX} >= GW_L) || ({1'b0, TgtY} >= GH_L);
  assign moved = (CurX != sx_q) || (CurY != sy_q);
  assign stall_nx = moved ? '0 : stall_q + 1'b1;
  assign cnt_d = (start && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;

  // X is resolved before Y
  always_comb begin
    req = '0;
    priority case (1'b1)
      CurX < tx_q: req[BTN_R] = 1'b1;
      CurX > tx_q: req[BTN_L] = 1'b1;
      CurY < ty_q: req[BTN_D] = 1'b1;
      CurY > ty_q: req[BTN_U] = 1'b1;
      default:     req[BTN_S] = 1'b1;
    endcase
  end

  // The last gap cycle doubles as the re-compare cycle
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    stall_d = stall_q;
    err_d   = err_q;
    sel_d   = sel_q;
    start   = 1'b0;
    if (!go) begin
      state_d = ST_IDLE;
    end else begin
      unique case (1'b1)
        state_q == ST_IDLE: state_d = ST_WAIT;
        state_q == ST_WAIT: begin
          if (Tgt_valid) begin
            if (oor) begin
              err_d = 1'b1;
            end else begin
              tx_d    = TgtX;
              ty_d    = TgtY;
              err_d   = 1'b0;
              stall_d = '0;
              state_d = ST_CMP;
            end
          end
        end
        state_q == ST_CMP: begin
          start   = 1'b1;
          state_d = ST_PULSE;
        end
        state_q == ST_PULSE: state_d = ST_GAP;
        state_q == ST_GAP: begin
          if (done) begin
            if (sel_q) begin
              state_d = ST_WAIT;
            end else begin
              stall_d = stall_nx;
              if (stall_nx >= MS_L) begin
                err_d   = 1'b1;
                state_d = ST_WAIT;
              end else begin
                start   = 1'b1;
                state_d = ST_PULSE;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (start) begin
      sx_d  = CurX;
      sy_d  = CurY;
      sel_d = req[BTN_S];
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      tx_q    <= '0;
      ty_q    <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
      sel_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      stall_q <= stall_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
      rdy_q   <= (state_d == ST_WAIT);
      busy_q  <= (state_d == ST_CMP) || (state_d == ST_PULSE) ||
                 (state_d == ST_GAP);
      cnt_q   <= cnt_d;
    end
  end

  memory_btn_pulser #(
    .GAP_CYC (GAP_CYC)
  ) u_pulser (
    .clk_i   (Clk),
    .rst_ni  (Reset),
    .kill_i  (!go),
    .start_i (start),
    .req_i   (req),
    .btn_o   (btn),
    .done_o  (done)
  );

  assign Right     = btn[BTN_R];
  assign Left      = btn[BTN_L];
  assign Down      = btn[BTN_D];
  assign Up        = btn[BTN_U];
  assign Select    = btn[BTN_S];
  assign Tgt_ready = rdy_q;
  assign Busy      = busy_q;
  assign Err       = err_q;
  assign Presses   = cnt_q;

endmodule

// File: tb/tb_memory_autoplayer.sv
// Bench for memory_autoplayer with a game-cursor model.
// Table vectors, Qp/reset abort sequences and random targets.
module tb_memory_autoplayer;

  localparam int CW = 4;
  localparam int GW = 4;
  localparam int GH = 4;
  localparam int MS = 3;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic Enable = 1'b0;
  logic Qp = 1'b0;
  logic Tgt_valid = 1'b0;
  logic [CW-1:0] TgtX = '0;
  logic [CW-1:0] TgtY = '0;
  logic [CW-1:0] CurX, CurY;
  logic Tgt_ready, Right, Left, Down, Up, Select, Busy, Err;
  logic [7:0] Presses;

  int cx = 0;
  int cy = 0;
  int cyc = 0;
  int bad_oh = 0;
  bit frozen = 0;
  bit pos_req = 0;
  int pos_x = 0;
  int pos_y = 0;
  int acc_q[$];
  int log_b[$];
  int log_c[$];
  int exp_q[$];
  int nvec = 0;
  int nerr = 0;
  int exp_presses = 0;
  logic [2:0] nb;

  memory_autoplayer #(
    .CW(CW), .GRID_W(GW), .GRID_H(GH), .GAP_CYC(1), .MAX_STALL(MS)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .Qp(Qp),
    .CurX(CurX), .CurY(CurY), .TgtX(TgtX), .TgtY(TgtY),
    .Tgt_valid(Tgt_valid), .Tgt_ready(Tgt_ready),
    .Right(Right), .Left(Left), .Down(Down), .Up(Up),
    .Select(Select), .Busy(Busy), .Err(Err), .Presses(Presses)
  );

  always #5 Clk = ~Clk;

  assign CurX = CW'(cx);
  assign CurY = CW'(cy);
  assign nb = 3'(Right) + 3'(Left) + 3'(Down) + 3'(Up) + 3'(Select);

  // game cursor: a button seen in a cycle moves the cursor for the next one
  always @(posedge Clk) begin
    if (nb > 3'd1) bad_oh <= bad_oh + 1;
    if (Tgt_valid && Tgt_ready) acc_q.push_back(cyc);
    if (nb != 3'd0) begin
      log_c.push_back(cyc);
      log_b.push_back(Right ? 0 : Left ? 1 : Down ? 2 : Up ? 3 : 4);
    end
    if (pos_req) begin
      cx <= pos_x;
      cy <= pos_y;
    end else if (nb != 3'd0 && !frozen) begin
      if (Right && cx < GW-1) cx <= cx + 1;
      if (Left && cx > 0)     cx <= cx - 1;
      if (Down && cy < GH-1)  cy <= cy + 1;
      if (Up && cy > 0)       cy <= cy - 1;
    end
    cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // expected button codes: 0=R 1=L 2=D 3=U 4=S
  function automatic void build(input int sx, input int sy, input int tx,
                                input int ty, input bit frz, output bit e);
    int d;
    exp_q.delete();
    e = 0;
    if (tx >= GW || ty >= GH) begin
      e = 1;
      return;
    end
    if (frz && (sx != tx || sy != ty)) begin
      d = (sx < tx) ? 0 : (sx > tx) ? 1 : (sy < ty) ? 2 : 3;
      repeat (MS) exp_q.push_back(d);
      e = 1;
      return;
    end
    repeat ((tx > sx) ? tx - sx : 0) exp_q.push_back(0);
    repeat ((sx > tx) ? sx - tx : 0) exp_q.push_back(1);
    repeat ((ty > sy) ? ty - sy : 0) exp_q.push_back(2);
    repeat ((sy > ty) ? sy - ty : 0) exp_q.push_back(3);
    exp_q.push_back(4);
  endfunction

  task automatic setcur(input int x, input int y);
    pos_x = x;
    pos_y = y;
    pos_req = 1;
    @(negedge Clk);
    pos_req = 0;
  endtask

  task automatic do_reset();
    Reset = 0;
    repeat (2) @(negedge Clk);
    Reset = 1;
    @(negedge Clk);
    exp_presses = 0;
  endtask

  task automatic offer(input int tx, input int ty, output bit ok);
    int i;
    ok = 0;
    i = 0;
    acc_q.delete();
    TgtX = CW'(tx);
    TgtY = CW'(ty);
    Tgt_valid = 1;
    while (!ok && i < 20) begin
      @(negedge Clk);
      if (acc_q.size() > 0) ok = 1;
      i++;
    end
    Tgt_valid = 0;
    chk($sformatf("accept(%0d,%0d)", tx, ty), int'(ok), 1);
  endtask

  task automatic run_target(input string nm, input int tx, input int ty,
                            input bit frz, input int np, input int ee);
    bit ok, e;
    int acc, n, sx, sy, m;
    sx = cx;
    sy = cy;
    frozen = frz;
    build(sx, sy, tx, ty, frz, e);
    log_b.delete();
    log_c.delete();
    offer(tx, ty, ok);
    if (ok) begin
      acc = acc_q[0];
      n = 0;
      while (!Tgt_ready && n < 200) begin
        @(negedge Clk);
        n++;
      end
      chk({nm, " done_in_time"}, int'(n < 200), 1);
      repeat (3) @(negedge Clk);
      exp_presses += exp_q.size();
      if (exp_presses > 255) exp_presses = 255;
      chk({nm, " npulses"}, log_b.size(), exp_q.size());
      if (np >= 0) chk({nm, " npulses_tbl"}, log_b.size(), np);
      m = (log_b.size() < exp_q.size()) ? log_b.size() : exp_q.size();
      for (int i = 0; i < m; i++) begin
        chk($sformatf("%s btn%0d", nm, i), log_b[i], exp_q[i]);
        chk($sformatf("%s cyc%0d", nm, i), log_c[i] - acc, 2 + 2*i);
      end
      chk({nm, " err"}, int'(Err), int'(e));
      if (ee >= 0) chk({nm, " err_tbl"}, int'(Err), ee);
      chk({nm, " presses"}, int'(Presses), exp_presses);
      chk({nm, " ready"}, int'(Tgt_ready), 1);
      chk({nm, " busy"}, int'(Busy), 0);
      if (!e) begin
        chk({nm, " curx"}, cx, tx);
        chk({nm, " cury"}, cy, ty);
      end
    end
    frozen = 0;
  endtask

  typedef struct {
    bit rst;
    int sx, sy, tx, ty;
    bit frz;
    int np;
    int err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    bit ok;
    int n, tx, ty;
    tbl[0] = '{1'b1, 0, 0, 1, 1, 1'b0, 3, 0};
    tbl[1] = '{1'b0, 2, 3, 0, 0, 1'b0, 6, 0};
    tbl[2] = '{1'b0, 0, 0, 4, 0, 1'b0, 0, 1};
    tbl[3] = '{1'b0, 0, 0, 0, 0, 1'b0, 1, 0};
    tbl[4] = '{1'b1, 0, 0, 2, 0, 1'b1, 3, 1};
    tbl[5] = '{1'b0, 3, 3, 3, 3, 1'b0, 1, 0};
    tbl[6] = '{1'b0, 1, 1, 0, 4, 1'b0, 0, 1};
    tbl[7] = '{1'b0, 1, 1, 3, 0, 1'b0, 4, 0};

    Enable = 1;
    Qp = 1;
    Tgt_valid = 1;
    Reset = 0;
    repeat (2) @(negedge Clk);
    chk("rst_outs", int'({Right, Left, Down, Up, Select, Busy, Err, Tgt_ready}), 0);
    chk("rst_presses", int'(Presses), 0);
    Reset = 1;
    @(negedge Clk);
    chk("rst_ready", int'(Tgt_ready), 1);
    chk("rst_busy", int'(Busy), 0);
    Tgt_valid = 0;
    @(negedge Clk);
    chk("rst_no_accept", acc_q.size(), 0);
    chk("rst_ready_hold", int'(Tgt_ready), 1);

    for (int v = 0; v < 8; v++) begin
      if (tbl[v].rst) do_reset();
      setcur(tbl[v].sx, tbl[v].sy);
      run_target($sformatf("vec%0d", v), tbl[v].tx, tbl[v].ty,
                 tbl[v].frz, tbl[v].np, tbl[v].err);
    end

    // Qp drop right after the first pulse
    do_reset();
    setcur(0, 0);
    log_b.delete();
    offer(3, 0, ok);
    n = 0;
    while (!Right && n < 20) begin
      @(negedge Clk);
      n++;
    end
    chk("qp_first_right", int'(Right), 1);
    Qp = 0;
    @(negedge Clk);
    chk("qp_busy", int'(Busy), 0);
    chk("qp_btns", int'({Right, Left, Down, Up, Select}), 0);
    repeat (5) @(negedge Clk);
    chk("qp_npulses", log_b.size(), 1);
    chk("qp_presses", int'(Presses), 1);
    chk("qp_ready", int'(Tgt_ready), 0);
    Qp = 1;
    @(negedge Clk);
    chk("qp_rewait", int'(Tgt_ready), 1);

    // reset in the middle of a target
    setcur(0, 0);
    log_b.delete();
    offer(3, 0, ok);
    n = 0;
    while (!Right && n < 20) begin
      @(negedge Clk);
      n++;
    end
    chk("mrst_first_right", int'(Right), 1);
    Reset = 0;
    @(negedge Clk);
    chk("mrst_outs", int'({Right, Left, Down, Up, Select, Busy, Err, Tgt_ready}), 0);
    chk("mrst_presses", int'(Presses), 0);
    Reset = 1;
    @(negedge Clk);
    chk("mrst_ready", int'(Tgt_ready), 1);
    repeat (3) @(negedge Clk);
    chk("mrst_npulses", log_b.size(), 1);
    exp_presses = 0;

    // random targets; long enough to saturate Presses
    for (int k = 0; k < 120; k++) begin
      if ($urandom_range(0, 3) == 0)
        setcur($urandom_range(0, GW-1), $urandom_range(0, GH-1));
      tx = $urandom_range(0, GW-1);
      ty = $urandom_range(0, GH-1);
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 1) tx = $urandom_range(GW, 15);
        else ty = $urandom_range(GH, 15);
      end
      run_target($sformatf("rnd%0d", k), tx, ty,
                 $urandom_range(0, 9) == 0, -1, -1);
    end

    chk("onehot", bad_oh, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
